// File: rtl/fsub_seq.sv
// fsub_seq: multi-cycle floating-point subtractor, Result = A - B.
// Handles binary32, or binary16 when both operands have zero upper halves.
// Denormal operands are flushed to zero and there is no rounding.
// Normalization after cancellation shifts one bit per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake (in_ready high only in idle)
//   A, B                minuend, subtrahend
//   out_valid/out_ready result handshake (out_valid high only in done)
//   Result              difference; binary16 results are zero-extended
//   busy                high whenever an operation is in flight
module fsub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Result,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StAlign, StSub, StNorm, StDone} state_e;

  state_e      state_q, state_d;
  logic        mode16_q, mode16_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sign_q, sign_d;
  logic        sub_q, sub_d;
  logic [8:0]  exp_q, exp_d;     // one spare bit so the carry increment cannot wrap
  logic [23:0] ml_q, ml_d;
  logic [23:0] ms_q, ms_d;
  logic [24:0] m_q, m_d;         // mantissa plus carry bit
  logic [31:0] result_q, result_d;

  // Operand field decode for the latched mode.
  logic        sa, sb_eff, a_ge_b, carry_bit, hid_bit;
  logic [7:0]  ea, eb, diff;
  logic [22:0] fa, fb;
  logic [23:0] ma, mb, hidden, ms_raw, ms_shift;
  logic [4:0]  mw;
  logic [8:0]  exp_max, exp_inc;
  logic [24:0] m_half;

  assign sa     = mode16_q ? a_q[15] : a_q[31];
  assign sb_eff = ~(mode16_q ? b_q[15] : b_q[31]);  // subtract = add with B negated
  assign ea     = mode16_q ? {3'b0, a_q[14:10]} : a_q[30:23];
  assign eb     = mode16_q ? {3'b0, b_q[14:10]} : b_q[30:23];
  assign fa     = mode16_q ? {13'b0, a_q[9:0]} : a_q[22:0];
  assign fb     = mode16_q ? {13'b0, b_q[9:0]} : b_q[22:0];
  assign hidden = mode16_q ? 24'h00_0400 : 24'h80_0000;
  assign ma     = (ea == 8'd0) ? 24'd0 : ({1'b0, fa} | hidden);
  assign mb     = (eb == 8'd0) ? 24'd0 : ({1'b0, fb} | hidden);
  assign mw     = mode16_q ? 5'd11 : 5'd24;

  // Magnitude order: exponent first, mantissa breaks ties; A wins on equality.
  assign a_ge_b   = {ea, ma} >= {eb, mb};
  assign diff     = a_ge_b ? (ea - eb) : (eb - ea);
  assign ms_raw   = a_ge_b ? mb : ma;
  assign ms_shift = (diff >= {3'b0, mw}) ? 24'd0 : (ms_raw >> diff);

  assign carry_bit = mode16_q ? m_q[11] : m_q[24];
  assign hid_bit   = mode16_q ? m_q[10] : m_q[23];
  assign exp_max   = mode16_q ? 9'd31 : 9'd255;
  assign exp_inc   = exp_q + 9'd1;
  assign m_half    = m_q >> 1;

  // Packs sign/exponent/fraction; an all-ones or larger exponent saturates to infinity.
  function automatic logic [31:0] pack(input logic m16, input logic s, input logic [8:0] e,
                                       input logic [8:0] emax, input logic [22:0] frac);
    if (e >= emax) begin
      pack = m16 ? {16'b0, s, 5'h1f, 10'b0} : {s, 8'hff, 23'b0};
    end else begin
      pack = m16 ? {16'b0, s, e[4:0], frac[9:0]} : {s, e[7:0], frac};
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    mode16_d = mode16_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    exp_d    = exp_q;
    ml_d     = ml_q;
    ms_d     = ms_q;
    m_d      = m_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          mode16_d = (A[31:16] == 16'd0) && (B[31:16] == 16'd0);
          state_d  = StAlign;
        end
      end
      StAlign: begin
        sign_d  = a_ge_b ? sa : sb_eff;
        sub_d   = sa ^ sb_eff;
        exp_d   = {1'b0, a_ge_b ? ea : eb};
        ml_d    = a_ge_b ? ma : mb;
        ms_d    = ms_shift;
        state_d = StSub;
      end
      StSub: begin
        m_d     = sub_q ? ({1'b0, ml_q} - {1'b0, ms_q}) : ({1'b0, ml_q} + {1'b0, ms_q});
        state_d = StNorm;
      end
      StNorm: begin
        if (m_q == 25'd0) begin
          result_d = 32'd0;
          state_d  = StDone;
        end else if (carry_bit) begin
          m_d      = m_half;
          exp_d    = exp_inc;
          result_d = pack(mode16_q, sign_q, exp_inc, exp_max, m_half[22:0]);
          state_d  = StDone;
        end else if (hid_bit) begin
          result_d = pack(mode16_q, sign_q, exp_q, exp_max, m_q[22:0]);
          state_d  = StDone;
        end else if (exp_q <= 9'd1) begin
          // Another shift would underflow the exponent: flush to +0.
          result_d = 32'd0;
          state_d  = StDone;
        end else begin
          m_d   = m_q << 1;
          exp_d = exp_q - 9'd1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mode16_q <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      exp_q    <= 9'd0;
      ml_q     <= 24'd0;
      ms_q     <= 24'd0;
      m_q      <= 25'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      mode16_q <= mode16_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      exp_q    <= exp_d;
      ml_q     <= ml_d;
      ms_q     <= ms_d;
      m_q      <= m_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign Result    = result_q;

endmodule
